// File: rtl/diffeq_controller.sv
// diffeq_controller
//
// Sequencing FSM for the differential-equation solver datapath. On a start
// request it streams four operands into the datapath (x, dx, a, u). It then
// steps the datapath through COMPUTE_1..COMPUTE_4 once per loop iteration
// until the datapath reports that the loop has ended. A watchdog bounds the
// time spent in each COMPUTE state, and an iteration cap bounds the loop.
// Both limits end the run with a sticky error flag.
//
// Parameters
//   MAX_ITER  iteration cap; reaching it ends the run with err_iter
//   ITER_W    width of iter_count (MAX_ITER <= 2^ITER_W - 1)
//   TIMEOUT   max cycles in one COMPUTE state without compute_done (>= 1)
//   TO_W      width of the watchdog counter (TIMEOUT <= 2^TO_W - 1)
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   start           run request, sampled only in IDLE
//   in_valid        operand on the datapath input bus is valid
//   compute_done    datapath finished the current COMPUTE state
//   continue_while  datapath loop condition, sampled only in COMPUTE_4
//   state           datapath phase encoding (IDLE=000 .. DONE=110)
//   in_ready        high for the whole READ state
//   load_x/dx/a/u   operand load strobes (Mealy on in_valid)
//   busy            high in every state except IDLE
//   done            one-cycle completion pulse in DONE
//   err_timeout     sticky: a watchdog expiry ended the run
//   err_iter        sticky: the iteration cap ended the run
//   iter_count      completed COMPUTE_4 exits in the current run
module diffeq_controller #(
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8,
  parameter int TIMEOUT  = 15,
  parameter int TO_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic              compute_done,
  input  logic              continue_while,
  output logic [2:0]        state,
  output logic              in_ready,
  output logic              load_x,
  output logic              load_dx,
  output logic              load_a,
  output logic              load_u,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_iter,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_READ = 3'b001,
    S_C1   = 3'b010,
    S_C2   = 3'b011,
    S_C3   = 3'b100,
    S_C4   = 3'b101,
    S_DONE = 3'b110
  } state_t;

  localparam logic [TO_W-1:0]   WD_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   iter_inc;
  logic                err_to_q, err_to_d;
  logic                err_it_q, err_it_d;

  assign iter_inc = iter_q + ITER_W'(1);

  // Next-state logic. The watchdog is cleared whenever a COMPUTE state is
  // left on compute_done, which is exactly the entry into the next COMPUTE
  // state (or DONE, where its value is irrelevant).
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    iter_d   = iter_q;
    err_to_d = err_to_q;
    err_it_d = err_it_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_READ;
          idx_d    = 2'd0;
          iter_d   = '0;
          err_to_d = 1'b0;
          err_it_d = 1'b0;
        end
      end

      S_READ: begin
        if (in_valid) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = S_C1;
            wd_d    = '0;
          end
        end
      end

      S_C1, S_C2, S_C3, S_C4: begin
        if (compute_done) begin
          wd_d = '0;
          case (state_q)
            S_C1:    state_d = S_C2;
            S_C2:    state_d = S_C3;
            S_C3:    state_d = S_C4;
            default: begin
              iter_d = iter_inc;
              if (!continue_while) begin
                state_d = S_DONE;
              end else if (iter_inc == ITER_CAP) begin
                state_d  = S_DONE;
                err_it_d = 1'b1;
              end else begin
                state_d = S_C1;
              end
            end
          endcase
        end else if (wd_q == WD_LAST) begin
          // The watchdog already covers TIMEOUT cycles in this state.
          state_d  = S_DONE;
          err_to_d = 1'b1;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;

      // Covers the unused encoding 111.
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      wd_q     <= '0;
      iter_q   <= '0;
      err_to_q <= 1'b0;
      err_it_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q  <= state_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      iter_q   <= iter_d;
      err_to_q <= err_to_d;
      err_it_q <= err_it_d;
    end
  end

  // Outputs decoded from registered state; the strobes are Mealy on in_valid.
  assign state       = state_q;
  assign in_ready    = (state_q == S_READ);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign load_x      = in_ready && (idx_q == 2'd0) && in_valid;
  assign load_dx     = in_ready && (idx_q == 2'd1) && in_valid;
  assign load_a      = in_ready && (idx_q == 2'd2) && in_valid;
  assign load_u      = in_ready && (idx_q == 2'd3) && in_valid;
  assign err_timeout = err_to_q;
  assign err_iter    = err_it_q;
  assign iter_count  = iter_q;

endmodule

// File: tb/tb_diffeq_controller.sv
// Testbench for diffeq_controller (MAX_ITER=4, TIMEOUT=15).
// The stimulus pushes expected strobe/done events, with their cycle numbers
// relative to the start edge, into a scoreboard queue. A monitor on the
// falling edge pops and compares one entry each time the DUT shows a strobe
// or a done pulse.
module tb_diffeq_controller;

  localparam int MAX_ITER = 4;
  localparam int ITER_W   = 8;
  localparam int TIMEOUT  = 15;
  localparam int TO_W     = 4;

  localparam int EV_X = 0, EV_DX = 1, EV_A = 2, EV_U = 3, EV_DONE = 4;

  typedef struct {
    int              ev;
    int              cyc;
    logic [ITER_W-1:0] iter;
    logic            eto;
    logic            eit;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, in_valid, compute_done, continue_while;
  logic [2:0]        state;
  logic              in_ready, load_x, load_dx, load_a, load_u;
  logic              busy, done, err_timeout, err_iter;
  logic [ITER_W-1:0] iter_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cnt = 0;
  exp_t sb[$];

  diffeq_controller #(
    .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .compute_done(compute_done), .continue_while(continue_while),
    .state(state), .in_ready(in_ready), .load_x(load_x), .load_dx(load_dx),
    .load_a(load_a), .load_u(load_u), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_iter(err_iter), .iter_count(iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int ev, input int c, input int it, input logic eto, input logic eit);
    exp_t e;
    e.ev = ev; e.cyc = c; e.iter = ITER_W'(it); e.eto = eto; e.eit = eit;
    sb.push_back(e);
  endfunction

  function automatic void push_loads(input int cx, input int cdx, input int ca, input int cu);
    push(EV_X, cx, 0, 0, 0);
    push(EV_DX, cdx, 0, 0, 0);
    push(EV_A, ca, 0, 0, 0);
    push(EV_U, cu, 0, 0, 0);
  endfunction

  task automatic sb_compare(input int ev, input int rel);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got event %0d at cycle %0d expected none", ev, rel);
    end else begin
      e = sb.pop_front();
      check("sb_event", ev, e.ev);
      check($sformatf("sb_cycle_ev%0d", e.ev), rel, e.cyc);
      if (e.ev == EV_DONE) begin
        check("sb_iter_count", iter_count, e.iter);
        check("sb_err_timeout", err_timeout, e.eto);
        check("sb_err_iter", err_iter, e.eit);
      end
    end
  endtask

  task automatic monitor_cycle();
    logic [3:0] strobes;
    int rel;
    strobes = {load_u, load_a, load_dx, load_x};
    rel = cyc - start_cnt + 1;
    if (strobes != 4'b0) begin
      check("strobe_onehot", $countones(strobes), 1);
      if (load_x)       sb_compare(EV_X, rel);
      else if (load_dx) sb_compare(EV_DX, rel);
      else if (load_a)  sb_compare(EV_A, rel);
      else              sb_compare(EV_U, rel);
    end
    if (done) sb_compare(EV_DONE, rel);
  endtask

  always @(negedge clk) begin
    if (!reset) monitor_cycle();
  end

  task automatic idle_inputs();
    start = 1'b0; in_valid = 1'b0; compute_done = 1'b0; continue_while = 1'b0;
  endtask

  // Called at posedge+1 while in IDLE; returns at posedge+1 of cycle 1.
  task automatic do_start();
    idle_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start_cnt = cyc;
    start = 1'b0;
    check("start_state_read", state, 3'b001);
    check("start_in_ready", in_ready, 1'b1);
    check("start_busy", busy, 1'b1);
  endtask

  // Drives cycles 1..n; bit k-1 of each mask is the input value in cycle k.
  // Character k-1 of st is the expected state digit in cycle k ('.' = skip).
  task automatic drive(input int n, input logic [63:0] ivm, input logic [63:0] cdm,
                       input logic [63:0] cwm, input string st);
    byte c;
    for (int k = 1; k <= n; k++) begin
      in_valid       = ivm[k-1];
      compute_done   = cdm[k-1];
      continue_while = cwm[k-1];
      c = st.getc(k - 1);
      if (c != ".") check($sformatf("state_cycle%0d", k), state, 32'(c - 8'd48));
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {state, in_ready, load_x, load_dx, load_a, load_u, busy, done,
                 err_timeout, err_iter, iter_count}, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #2;
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single iteration: strobes in cycles 1-4, DONE in cycle 9.
    push_loads(1, 2, 3, 4);
    push(EV_DONE, 9, 1, 0, 0);
    do_start();
    drive(10, '1, '1, '0, "1111234560");
    check("single_busy_idle", busy, 1'b0);
    check("single_iter_hold", iter_count, 1);

    // Operand gaps: in_valid 1,0,0,1,1,0,1 then COMPUTE_1 in cycle 8.
    push_loads(1, 4, 5, 7);
    push(EV_DONE, 12, 1, 0, 0);
    do_start();
    drive(13, 64'h59, '1, '0, "1111111234560");

    // Three iterations: continue_while drops only for the third COMPUTE_4.
    push_loads(1, 2, 3, 4);
    push(EV_DONE, 17, 3, 0, 0);
    do_start();
    drive(18, '1, '1, 64'h7FFF, "111123452345234560");

    // Timeout: stuck in COMPUTE_2 for 15 cycles (6..20), DONE in 21.
    push_loads(1, 2, 3, 4);
    push(EV_DONE, 21, 0, 1, 0);
    do_start();
    drive(22, '1, 64'h10, '0, "1111233333333333333360");
    check("timeout_flag_hold", err_timeout, 1'b1);
    check("timeout_iter_hold", iter_count, 0);

    // Iteration cap: four COMPUTE_4 exits, DONE in cycle 21.
    push_loads(1, 2, 3, 4);
    push(EV_DONE, 21, 4, 0, 1);
    do_start();
    check("cap_start_clears_timeout", err_timeout, 1'b0);
    drive(22, '1, '1, '1, "1111234523452345234560");
    check("cap_flag_hold", err_iter, 1'b1);
    check("cap_iter_hold", iter_count, 4);

    // Reset in COMPUTE_3 of a new run: immediate IDLE, no done pulse.
    push_loads(1, 2, 3, 4);
    do_start();
    drive(6, '1, '1, '1, "111123");
    check("pre_reset_c3", state, 3'b100);
    in_valid = 1'b1;
    compute_done = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("midrun_reset_outputs");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    drive(4, '0, '1, '1, "0000");

    // Normal run after the reset.
    push_loads(1, 2, 3, 4);
    push(EV_DONE, 9, 1, 0, 0);
    do_start();
    drive(10, '1, '1, '0, "1111234560");

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
